// File: rtl/wb_regfile.sv
// wb_regfile: write-back mux, 32-entry register file with write-through read bypass, and commit counter
//   clk, rst                   rising-edge clock, asynchronous active-high reset
//   wb_dm_out, wb_dm_alu_out   load data / ALU result from the DM/WB buffer
//   wb_dm_rd_out_addr          destination register
//   wb_dm_w_enable             commit write-back this cycle
//   wb_dm_wb_mux_ctrl          1 = load data, 0 = ALU result
//   rs1_addr, rs2_addr         decode read addresses
//   rs1_data, rs2_data         combinational read data (x0 = 0, bypass of same-cycle write)
//   wb_data                    selected write-back value for EX forwarding
//   wb_commit_cnt              count of committed write-backs, wraps
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] wb_dm_out,
    input  logic [DATA_W-1:0] wb_dm_alu_out,
    input  logic [ADDR_W-1:0] wb_dm_rd_out_addr,
    input  logic              wb_dm_w_enable,
    input  logic              wb_dm_wb_mux_ctrl,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic [DATA_W-1:0] wb_data,
    output logic [CNT_W-1:0]  wb_commit_cnt
);
    logic [DATA_W-1:0] r_regs [0:2**ADDR_W-1];
    logic [CNT_W-1:0]  r_cnt;
    always_comb begin
        wb_data  = wb_dm_wb_mux_ctrl ? wb_dm_out : wb_dm_alu_out;
        rs1_data = (rs1_addr == '0) ? '0 :
                   (wb_dm_w_enable && wb_dm_rd_out_addr == rs1_addr) ? wb_data : r_regs[rs1_addr];
        rs2_data = (rs2_addr == '0) ? '0 :
                   (wb_dm_w_enable && wb_dm_rd_out_addr == rs2_addr) ? wb_data : r_regs[rs2_addr];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2**ADDR_W; i++) r_regs[i] <= '0;
            r_cnt <= '0;
        end else if (wb_dm_w_enable) begin
            if (wb_dm_rd_out_addr != '0) r_regs[wb_dm_rd_out_addr] <= wb_data;
            r_cnt <= r_cnt + 1'b1;
        end
    end
    assign wb_commit_cnt = r_cnt;
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed self-checking bench for wb_regfile
module tb_wb_regfile;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dm, alu;
    logic [4:0]  rd, ra1, ra2;
    logic        en, mux;
    logic [31:0] rs1, rs2, wbd, cnt;
    logic [31:0] s_rs1, s_rs2, s_wbd;
    logic [2:0]  s_cnt;
    int checks = 0;
    int errors = 0;

    wb_regfile dut (
        .clk(clk), .rst(rst), .wb_dm_out(dm), .wb_dm_alu_out(alu),
        .wb_dm_rd_out_addr(rd), .wb_dm_w_enable(en), .wb_dm_wb_mux_ctrl(mux),
        .rs1_addr(ra1), .rs2_addr(ra2), .rs1_data(rs1), .rs2_data(rs2),
        .wb_data(wbd), .wb_commit_cnt(cnt)
    );

    wb_regfile #(.CNT_W(3)) u_w (
        .clk(clk), .rst(rst), .wb_dm_out(dm), .wb_dm_alu_out(alu),
        .wb_dm_rd_out_addr(rd), .wb_dm_w_enable(en), .wb_dm_wb_mux_ctrl(mux),
        .rs1_addr(ra1), .rs2_addr(ra2), .rs1_data(s_rs1), .rs2_data(s_rs2),
        .wb_data(s_wbd), .wb_commit_cnt(s_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; dm = '0; alu = '0; rd = '0; ra1 = '0; ra2 = '0; en = 1'b0; mux = 1'b0;
        tick; tick;
        ra1 = 5;
        #1 chk("reset_cnt", cnt, 32'h0);
        chk("reset_x5", rs1, 32'h0);
        rst = 1'b0;
        tick;
        en = 1'b1; rd = 5; alu = 32'h1234;
        tick;
        en = 1'b0;
        #1 chk("preload_x5", rs1, 32'h1234);
        chk("preload_cnt", cnt, 32'h1);
        #1 rst = 1'b1;
        #1 chk("async_rst_x5", rs1, 32'h0);
        chk("async_rst_cnt", cnt, 32'h0);
        en = 1'bx; rd = 'x;
        tick;
        chk("rst_x_ctrl_cnt", cnt, 32'h0);
        en = 1'b0; rd = 5;
        #1 chk("rst_x_ctrl_x5", rs1, 32'h0);
        rst = 1'b0;
        tick;
        en = 1'b1; mux = 1'b0; alu = 32'hDEADBEEF; dm = 32'h5555; rd = 7;
        #1 chk("wb_mux_alu", wbd, 32'hDEADBEEF);
        tick;
        en = 1'b0; ra1 = 7;
        #1 chk("alu_wb_x7", rs1, 32'hDEADBEEF);
        chk("alu_wb_cnt", cnt, 32'h1);
        en = 1'b1; mux = 1'b1; dm = 32'hA5; rd = 3; ra1 = 3; ra2 = 3;
        #1 chk("wb_mux_dm", wbd, 32'hA5);
        chk("bypass_rs1", rs1, 32'hA5);
        chk("bypass_rs2", rs2, 32'hA5);
        tick;
        en = 1'b0;
        #1 chk("load_x3", rs1, 32'hA5);
        chk("load_cnt", cnt, 32'h2);
        en = 1'b1; mux = 1'b0; rd = 0; alu = 32'hFFFFFFFF; ra1 = 0;
        #1 chk("x0_same_cycle", rs1, 32'h0);
        tick;
        en = 1'b0;
        #1 chk("x0_after", rs1, 32'h0);
        chk("x0_cnt", cnt, 32'h3);
        en = 1'b1; rd = 9; alu = 32'h11;
        tick;
        en = 1'b0; alu = 32'h55; ra1 = 9; ra2 = 9;
        #1 chk("en_low_nobypass", rs1, 32'h11);
        chk("en_low_cnt_pre", cnt, 32'h4);
        tick;
        chk("en_low_x9", rs2, 32'h11);
        chk("en_low_cnt", cnt, 32'h4);
        en = 1'b1; rd = 7; alu = 32'h77; ra1 = 7; ra2 = 9;
        #1 chk("indep_rs1_bypass", rs1, 32'h77);
        chk("indep_rs2_array", rs2, 32'h11);
        ra2 = 3;
        #1 chk("indep_rs2_x3", rs2, 32'hA5);
        tick;
        en = 1'b0; ra1 = 7;
        #1 chk("x7_overwritten", rs1, 32'h77);
        chk("cnt5", cnt, 32'h5);
        chk("small_cnt5", {29'b0, s_cnt}, 32'h5);
        en = 1'b1; rd = 0;
        tick; tick;
        chk("small_cnt_max", {29'b0, s_cnt}, 32'h7);
        tick;
        en = 1'b0;
        #1 chk("wrap_cnt", {29'b0, s_cnt}, 32'h0);
        chk("main_cnt8", cnt, 32'h8);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
